// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory request/response bus between fetch stage and imem
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage with variable-latency imem; FETCH_TIMEOUT_EN adds a fetch watchdog
module instr_fetch
`ifdef FETCH_TIMEOUT_EN
  #(parameter int TIMEOUT = 15)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  instr_fetch_if.master imem,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        consume,
  output logic        fetch_stall,
  output logic        fetch_err
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t      state;
  logic [29:0] pc_reg;
  logic        unused_pc_hi;
  assign unused_pc_hi = ^pc_in[31:30];
  assign imem.imem_addr = {pc_reg, 2'b00};
  assign fetch_stall = !instr_valid;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else if (state != FETCH) begin
      cnt <= '0;
    end else if (!imem.imem_ready) begin
      cnt       <= cnt + 1'b1;
      fetch_err <= fetch_err | (cnt == CW'(TIMEOUT - 1));
    end
  end
  wire expire = !imem.imem_ready && cnt == CW'(TIMEOUT - 1);
`else
  assign fetch_err = 1'b0;
  wire expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc_reg        <= '0;
      imem.imem_req <= 1'b0;
      instr_out     <= 32'h0;
      instr_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc_reg        <= pc_in[29:0];
          imem.imem_req <= 1'b1;
          state         <= FETCH;
        end
        FETCH: if (imem.imem_ready || expire) begin
          instr_out     <= imem.imem_ready ? imem.imem_rdata : 32'h0;
          instr_valid   <= 1'b1;
          imem.imem_req <= 1'b0;
          state         <= HOLD;
        end
        HOLD: if (consume) begin
          pc_reg        <= pc_in[29:0];
          instr_valid   <= 1'b0;
          imem.imem_req <= 1'b1;
          state         <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of the fetch stage; define FETCH_TIMEOUT_EN to also cover the watchdog
module tb_instr_fetch;
  logic        clk = 0, rst = 1, consume = 0;
  logic [31:0] pc_in = 0;
  logic [31:0] instr_out;
  logic        instr_valid, fetch_stall, fetch_err;
  int          n = 0, nfail = 0;
  instr_fetch_if bus();
`ifdef FETCH_TIMEOUT_EN
  instr_fetch #(.TIMEOUT(4)) dut (
`else
  instr_fetch dut (
`endif
    .clk(clk), .rst(rst), .pc_in(pc_in), .imem(bus), .instr_out(instr_out),
    .instr_valid(instr_valid), .consume(consume), .fetch_stall(fetch_stall), .fetch_err(fetch_err));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; bus.imem_ready = 1; bus.imem_rdata = 32'hDEADBEEF; pc_in = 32'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      n++; if (bus.imem_req !== 1'b0) begin nfail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
      n++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n++; if (fetch_stall !== 1'b1) begin nfail++; $display("FAIL reset_stall: got %b want 1", fetch_stall); end
      n++; if (instr_out !== 32'h0) begin nfail++; $display("FAIL reset_instr: got %h want 0", instr_out); end
      n++; if (fetch_err !== 1'b0) begin nfail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
      n++; if (bus.imem_addr !== 32'h0) begin nfail++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    end
  endtask

  task automatic test_zero_wait();
    rst = 0; pc_in = 32'h4; bus.imem_ready = 1; bus.imem_rdata = 32'h8C220000;
    step();
    n++; if (bus.imem_req !== 1'b1) begin nfail++; $display("FAIL zw_req_e1: got %b want 1", bus.imem_req); end
    n++; if (bus.imem_addr !== 32'h10) begin nfail++; $display("FAIL zw_addr: got %h want 00000010", bus.imem_addr); end
    n++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL zw_valid_e1: got %b want 0", instr_valid); end
    step();
    n++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL zw_valid_e2: got %b want 1", instr_valid); end
    n++; if (instr_out !== 32'h8C220000) begin nfail++; $display("FAIL zw_instr: got %h want 8c220000", instr_out); end
    n++; if (fetch_stall !== 1'b0) begin nfail++; $display("FAIL zw_stall: got %b want 0", fetch_stall); end
    n++; if (bus.imem_req !== 1'b0) begin nfail++; $display("FAIL zw_req_e2: got %b want 0", bus.imem_req); end
  endtask

  task automatic test_hold_consume();
    consume = 0; bus.imem_rdata = 32'h12345678; pc_in = 32'h44;
    for (int i = 0; i < 5; i++) begin
      step();
      n++; if (instr_out !== 32'h8C220000) begin nfail++; $display("FAIL hold_instr: got %h want 8c220000", instr_out); end
      n++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL hold_valid: got %b want 1", instr_valid); end
      n++; if (bus.imem_req !== 1'b0) begin nfail++; $display("FAIL hold_req: got %b want 0", bus.imem_req); end
    end
    consume = 1; pc_in = 32'h8;
    step();
    consume = 0;
    n++; if (bus.imem_addr !== 32'h20) begin nfail++; $display("FAIL consume_addr: got %h want 00000020", bus.imem_addr); end
    n++; if (bus.imem_req !== 1'b1) begin nfail++; $display("FAIL consume_req: got %b want 1", bus.imem_req); end
    n++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL consume_valid: got %b want 0", instr_valid); end
    n++; if (fetch_stall !== 1'b1) begin nfail++; $display("FAIL consume_stall: got %b want 1", fetch_stall); end
  endtask

  task automatic test_wait_states();
    bus.imem_ready = 0; pc_in = 32'h40; consume = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n++; if (bus.imem_req !== 1'b1) begin nfail++; $display("FAIL wait_req[%0d]: got %b want 1", i, bus.imem_req); end
      n++; if (bus.imem_addr !== 32'h20) begin nfail++; $display("FAIL wait_addr[%0d]: got %h want 00000020", i, bus.imem_addr); end
      n++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL wait_valid[%0d]: got %b want 0", i, instr_valid); end
    end
    consume = 0; bus.imem_ready = 1; bus.imem_rdata = 32'h10220003;
    step();
    n++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL wait_valid_end: got %b want 1", instr_valid); end
    n++; if (instr_out !== 32'h10220003) begin nfail++; $display("FAIL wait_instr: got %h want 10220003", instr_out); end
    n++; if (fetch_err !== 1'b0) begin nfail++; $display("FAIL wait_err: got %b want 0", fetch_err); end
  endtask

  task automatic test_back_to_back();
    consume = 1; pc_in = 32'h100; bus.imem_ready = 1; bus.imem_rdata = 32'hAAAA5555;
    step();
    n++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL b2b_gap: got %b want 0", instr_valid); end
    n++; if (bus.imem_addr !== 32'h400) begin nfail++; $display("FAIL b2b_addr: got %h want 00000400", bus.imem_addr); end
    step();
    n++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL b2b_valid: got %b want 1", instr_valid); end
    n++; if (instr_out !== 32'hAAAA5555) begin nfail++; $display("FAIL b2b_instr: got %h want aaaa5555", instr_out); end
    consume = 0;
  endtask

  task automatic test_reset_mid_fetch();
    consume = 1; pc_in = 32'h200; bus.imem_ready = 0;
    step();
    consume = 0;
    step();
    rst = 1; bus.imem_ready = 1; bus.imem_rdata = 32'hFFFFFFFF;
    step();
    n++; if (bus.imem_req !== 1'b0) begin nfail++; $display("FAIL rmid_req: got %b want 0", bus.imem_req); end
    n++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL rmid_valid: got %b want 0", instr_valid); end
    n++; if (bus.imem_addr !== 32'h0) begin nfail++; $display("FAIL rmid_addr: got %h want 0", bus.imem_addr); end
    rst = 0; pc_in = 32'h3;
    step();
    n++; if (instr_out !== 32'h0) begin nfail++; $display("FAIL rmid_discard: got %h want 0", instr_out); end
    n++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL rmid_valid_e1: got %b want 0", instr_valid); end
    n++; if (bus.imem_addr !== 32'hC) begin nfail++; $display("FAIL rmid_restart_addr: got %h want 0000000c", bus.imem_addr); end
    n++; if (bus.imem_req !== 1'b1) begin nfail++; $display("FAIL rmid_restart_req: got %b want 1", bus.imem_req); end
    step();
    n++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL rmid_refetch: got %b want 1", instr_valid); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    consume = 1; pc_in = 32'h10; bus.imem_ready = 0;
    step();
    consume = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n++; if (instr_valid !== 1'b0) begin nfail++; $display("FAIL to_valid_early[%0d]: got %b want 0", i, instr_valid); end
      n++; if (fetch_err !== 1'b0) begin nfail++; $display("FAIL to_err_early[%0d]: got %b want 0", i, fetch_err); end
    end
    step();
    n++; if (instr_valid !== 1'b1) begin nfail++; $display("FAIL to_valid: got %b want 1", instr_valid); end
    n++; if (instr_out !== 32'h0) begin nfail++; $display("FAIL to_instr: got %h want 0", instr_out); end
    n++; if (fetch_err !== 1'b1) begin nfail++; $display("FAIL to_err: got %b want 1", fetch_err); end
    n++; if (bus.imem_req !== 1'b0) begin nfail++; $display("FAIL to_req: got %b want 0", bus.imem_req); end
    consume = 1; bus.imem_ready = 1; bus.imem_rdata = 32'h00001234;
    step();
    consume = 0;
    step();
    n++; if (instr_out !== 32'h00001234) begin nfail++; $display("FAIL to_next_instr: got %h want 00001234", instr_out); end
    n++; if (fetch_err !== 1'b1) begin nfail++; $display("FAIL to_sticky: got %b want 1", fetch_err); end
    rst = 1;
    step();
    rst = 0;
    n++; if (fetch_err !== 1'b0) begin nfail++; $display("FAIL to_clear: got %b want 0", fetch_err); end
  endtask
`endif

  initial begin
    bus.imem_ready = 0; bus.imem_rdata = 0;
    test_reset();
    test_zero_wait();
    test_hold_consume();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n, nfail);
    $finish;
  end
endmodule
